split_target_mem: RTL and testbench

- Byte-wide memory target that sits directly behind the serial target port.
- Consumes the port's parallel address/data strobes, performs writes, and services reads after a fixed access latency.
- Returns read data to the port as a one-cycle parallel strobe, which the port then serializes.
- Optionally uses split transactions: it releases the bus during the access and re-requests it through the arbiter before returning data.

---
 rtl/split_target_mem.sv | 165 ++++++++++++++++
 tb/tb_split_target_mem.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/split_target_mem.sv
// split_target_mem: byte-wide memory target behind the serial target port. Split reads are built when SPLIT_TARGET_MEM_SPLIT_EN is defined.
// Latency: a write commits at its strobe edge and target_ack follows one cycle later. Read data strobes READ_LATENCY cycles after accept; in split mode it waits for the arbiter grant instead.
// Backpressure: target_ready is low outside IDLE. An address strobe arriving while busy is dropped and flagged on drop_err.
module split_target_mem #(
    parameter int ADDR_WIDTH     = 12,
    parameter int READ_LATENCY   = 4,
    parameter int TX_HOLD_CYCLES = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] target_addr_in,
    input  logic        target_addr_in_valid,
    input  logic [7:0]  target_data_in,
    input  logic        target_data_in_valid,
    input  logic        bus_rw,
    output logic        target_rw,
    output logic [7:0]  target_data_out,
    output logic        target_data_out_valid,
    output logic        target_ready,
    output logic        target_ack,
    output logic        target_split_ack,
    output logic        split_req,
    input  logic        split_grant,
    output logic        drop_err
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef SPLIT_TARGET_MEM_SPLIT_EN
    // The bus request overlaps the last latency cycle, so an immediate grant lands the strobe at READ_LATENCY+1.
    localparam logic [15:0] LAT_LOAD = 16'(READ_LATENCY - 1);
    typedef enum logic [1:0] {IDLE, RD_WAIT, SPLIT_REQ, TX_HOLD} state_t;
`else
    localparam logic [15:0] LAT_LOAD = 16'(READ_LATENCY);
    typedef enum logic [1:0] {IDLE, RD_WAIT, TX_HOLD} state_t;
`endif
    localparam logic [15:0] HOLD_LOAD = 16'(TX_HOLD_CYCLES);

    state_t                  state_q, state_d;
    logic [15:0]             lat_cnt_q, hold_cnt_q;
    logic [ADDR_WIDTH-1:0]   rd_idx_q;
    logic [7:0]              data_hold_q;
    logic                    ack_q, drop_q, rd_strobe;
    logic [7:0]              mem [DEPTH];

    wire  [ADDR_WIDTH-1:0]   idx      = target_addr_in[ADDR_WIDTH-1:0];
    wire                     in_idle  = (state_q == IDLE);
    wire                     wr_fire  = in_idle && target_addr_in_valid && target_data_in_valid;
    wire                     rd_fire  = in_idle && target_addr_in_valid && !target_data_in_valid;
    wire                     busy_hit = !in_idle && target_addr_in_valid;

    assign target_rw             = bus_rw;
    assign target_ready          = in_idle;
    assign target_ack            = ack_q;
    assign drop_err              = drop_q;
    assign target_data_out_valid = rd_strobe;
    // Read data comes straight from the array on the strobe cycle, then stays held until the next strobe.
    assign target_data_out       = rd_strobe ? mem[rd_idx_q] : data_hold_q;

`ifdef SPLIT_TARGET_MEM_SPLIT_EN
    logic split_ack_q, gnt_seen_q, req_c;
    logic unused_ok;
    assign unused_ok        = ^target_addr_in;
    assign target_split_ack = split_ack_q;
    assign split_req        = req_c;

    // Split handshake: acknowledge the accept and remember the grant for the strobe cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            split_ack_q <= 1'b0;
            gnt_seen_q  <= 1'b0;
        end else begin
            split_ack_q <= rd_fire;
            gnt_seen_q  <= (state_q == SPLIT_REQ) && !gnt_seen_q && split_grant;
        end
    end
`else
    logic unused_ok;
    assign unused_ok        = ^{target_addr_in, split_grant};
    assign target_split_ack = 1'b0;
    assign split_req        = 1'b0;
`endif

    // Next-state and decoded outputs.
    always_comb begin
        state_d   = state_q;
        rd_strobe = 1'b0;
`ifdef SPLIT_TARGET_MEM_SPLIT_EN
        req_c     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rd_fire) begin
`ifdef SPLIT_TARGET_MEM_SPLIT_EN
                    state_d = (READ_LATENCY == 1) ? SPLIT_REQ : RD_WAIT;
`else
                    state_d = RD_WAIT;
`endif
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == 16'd1) begin
`ifdef SPLIT_TARGET_MEM_SPLIT_EN
                    state_d = SPLIT_REQ;
`else
                    rd_strobe = 1'b1;
                    state_d   = TX_HOLD;
`endif
                end
            end
`ifdef SPLIT_TARGET_MEM_SPLIT_EN
            SPLIT_REQ: begin
                if (gnt_seen_q) begin
                    rd_strobe = 1'b1;
                    state_d   = TX_HOLD;
                end else begin
                    req_c = 1'b1;
                end
            end
`endif
            TX_HOLD: begin
                if (hold_cnt_q == 16'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, read index, held read data and registered pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lat_cnt_q   <= 16'd0;
            hold_cnt_q  <= 16'd0;
            rd_idx_q    <= '0;
            data_hold_q <= 8'h00;
            ack_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (rd_fire) begin
                lat_cnt_q <= LAT_LOAD;
                rd_idx_q  <= idx;
            end else if (state_q == RD_WAIT) begin
                lat_cnt_q <= lat_cnt_q - 16'd1;
            end
            if (state_d == TX_HOLD && state_q != TX_HOLD) begin
                hold_cnt_q <= HOLD_LOAD;
            end else if (state_q == TX_HOLD) begin
                hold_cnt_q <= hold_cnt_q - 16'd1;
            end
            if (rd_strobe) begin
                data_hold_q <= mem[rd_idx_q];
            end
            ack_q  <= wr_fire;
            drop_q <= busy_hit;
        end
    end

    // Memory array is never reset; writes are accepted only in IDLE.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[idx] <= target_data_in;
        end
    end
endmodule

// File: tb/tb_split_target_mem.sv
`timescale 1ns/1ps
// tb_split_target_mem: directed bench with a read-data scoreboard for split_target_mem.
// Expected read data and strobe cycle are queued at read issue and compared when the strobe appears.
// Mode-dependent expectations follow SPLIT_TARGET_MEM_SPLIT_EN.
module tb_split_target_mem;
    localparam int AW   = 12;
    localparam int LAT  = 4;
    localparam int HOLD = 9;
`ifdef SPLIT_TARGET_MEM_SPLIT_EN
    localparam int SPLIT = 1;
`else
    localparam int SPLIT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] target_addr_in;
    logic        target_addr_in_valid;
    logic [7:0]  target_data_in;
    logic        target_data_in_valid;
    logic        bus_rw;
    logic        target_rw;
    logic [7:0]  target_data_out;
    logic        target_data_out_valid;
    logic        target_ready;
    logic        target_ack;
    logic        target_split_ack;
    logic        split_req;
    logic        split_grant;
    logic        drop_err;

    always #5 clk = ~clk;

    split_target_mem #(.ADDR_WIDTH(AW), .READ_LATENCY(LAT), .TX_HOLD_CYCLES(HOLD)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .target_addr_in        (target_addr_in),
        .target_addr_in_valid  (target_addr_in_valid),
        .target_data_in        (target_data_in),
        .target_data_in_valid  (target_data_in_valid),
        .bus_rw                (bus_rw),
        .target_rw             (target_rw),
        .target_data_out       (target_data_out),
        .target_data_out_valid (target_data_out_valid),
        .target_ready          (target_ready),
        .target_ack            (target_ack),
        .target_split_ack      (target_split_ack),
        .split_req             (split_req),
        .split_grant           (split_grant),
        .drop_err              (drop_err)
    );

    typedef struct {
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] model [0:4095];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int strobes = 0;
    int acks = 0;
    int n_reads = 0;
    int n_writes = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs sampled 1ns after the edge, read strobes scored against the queue.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (target_data_out_valid === 1'b1) begin
            strobes++;
            chk("strobe_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("read_data", {24'd0, target_data_out}, {24'd0, e.data});
                chk("strobe_cycle", cyc, e.due);
                chk("split_req_on_strobe", {31'd0, split_req}, 32'd0);
            end
        end
        if (target_ack === 1'b1) acks++;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] data);
        target_addr_in       = addr;
        target_data_in       = data;
        target_addr_in_valid = 1'b1;
        target_data_in_valid = 1'b1;
        bus_rw               = 1'b1;
        step();
        model[addr[AW-1:0]] = data;
        n_writes++;
        chk("ack_after_write", {31'd0, target_ack}, 32'd1);
        chk("target_rw_write", {31'd0, target_rw}, 32'd1);
        chk("ready_after_write", {31'd0, target_ready}, 32'd1);
        target_addr_in_valid = 1'b0;
        target_data_in_valid = 1'b0;
        bus_rw               = 1'b0;
    endtask

    // Read with optional busy-time injection (inj = busy cycle index, -1 none) and grant delay.
    task automatic do_read(input logic [15:0] addr, input int inj, input logic inj_wr, input int gdelay);
        exp_t e;
        int   n;
        int   req_n;
        int   acc_cyc;
        acc_cyc              = cyc;
        target_addr_in       = addr;
        target_addr_in_valid = 1'b1;
        target_data_in_valid = 1'b0;
        bus_rw               = 1'b0;
        e.data = model[addr[AW-1:0]];
        e.due  = acc_cyc + LAT + SPLIT * (1 + gdelay);
        exp_q.push_back(e);
        n_reads++;
        step();
        target_addr_in_valid = 1'b0;
        chk("ready_low_after_accept", {31'd0, target_ready}, 32'd0);
        chk("target_rw_read", {31'd0, target_rw}, 32'd0);
        chk("split_ack", {31'd0, target_split_ack}, 32'(SPLIT));
        n = 0;
        req_n = 0;
        while (target_ready !== 1'b1 && n < 200) begin
            if (n == inj) begin
                target_addr_in       = 16'h0012;
                target_data_in       = 8'hEE;
                target_addr_in_valid = 1'b1;
                target_data_in_valid = inj_wr;
                bus_rw               = inj_wr;
                step();
                n++;
                target_addr_in_valid = 1'b0;
                target_data_in_valid = 1'b0;
                bus_rw               = 1'b0;
                chk("drop_err_busy", {31'd0, drop_err}, 32'd1);
                chk("no_ack_busy", {31'd0, target_ack}, 32'd0);
            end else begin
                if (split_req === 1'b1) begin
                    if (req_n == 0) chk("split_req_rise", cyc - acc_cyc, LAT);
                    split_grant = (req_n == gdelay);
                    req_n++;
                end else begin
                    split_grant = 1'b0;
                end
                step();
                n++;
            end
        end
        split_grant = 1'b0;
        chk("busy_cycles", n, LAT + HOLD + SPLIT * (1 + gdelay));
        chk("data_held", {24'd0, target_data_out}, {24'd0, e.data});
    endtask

    initial begin
        int s0;
        rst_n                = 1'b0;
        target_addr_in       = 16'h0000;
        target_addr_in_valid = 1'b0;
        target_data_in       = 8'h00;
        target_data_in_valid = 1'b0;
        bus_rw               = 1'b0;
        split_grant          = 1'b0;
        step();
        step();
        chk("rst_ready", {31'd0, target_ready}, 32'd1);
        chk("rst_data_out", {24'd0, target_data_out}, 32'd0);
        chk("rst_valid", {31'd0, target_data_out_valid}, 32'd0);
        chk("rst_ack", {31'd0, target_ack}, 32'd0);
        chk("rst_split_ack", {31'd0, target_split_ack}, 32'd0);
        chk("rst_split_req", {31'd0, split_req}, 32'd0);
        chk("rst_drop", {31'd0, drop_err}, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic write then read, then upper-address aliasing.
        do_write(16'h0012, 8'hA5);
        do_read(16'h0012, -1, 1'b0, 0);
        do_write(16'h1FFF, 8'h3C);
        do_read(16'h0FFF, -1, 1'b0, 0);

        // Strobes while busy: read in TX_HOLD, write in RD_WAIT; memory must be untouched.
        do_read(16'h0012, 6, 1'b0, 0);
        do_read(16'h0012, 1, 1'b1, 0);
        do_read(16'h0012, -1, 1'b0, 0);

        // Data strobe without address strobe is ignored.
        target_data_in       = 8'h99;
        target_data_in_valid = 1'b1;
        step();
        target_data_in_valid = 1'b0;
        chk("lone_data_no_ack", {31'd0, target_ack}, 32'd0);
        chk("lone_data_no_drop", {31'd0, drop_err}, 32'd0);

        // Back-to-back writes, then read them back.
        for (int i = 0; i < 4; i++) do_write(16'(i), 8'(i + 1));
        step();
        chk("ack_clears", {31'd0, target_ack}, 32'd0);
        for (int i = 0; i < 4; i++) do_read(16'(i), -1, 1'b0, 0);

        // Delayed grant (only shapes timing in split builds).
        do_write(16'h0040, 8'h77);
        do_read(16'h0040, -1, 1'b0, 5);

        // Reset in the middle of a read, with a drop pulse pending.
        target_addr_in       = 16'h0012;
        target_addr_in_valid = 1'b1;
        step();
        target_addr_in_valid = 1'b0;
        for (int i = 0; i < SPLIT * (LAT - 2); i++) step();
        target_addr_in_valid = 1'b1;
        step();
        target_addr_in_valid = 1'b0;
        chk("drop_before_reset", {31'd0, drop_err}, 32'd1);
        chk("split_req_before_reset", {31'd0, split_req}, 32'(SPLIT));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_split_req", {31'd0, split_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, target_data_out_valid}, 32'd0);
        chk("mid_rst_drop", {31'd0, drop_err}, 32'd0);
        chk("mid_rst_ready", {31'd0, target_ready}, 32'd1);
        s0 = strobes;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) step();
        chk("no_strobe_after_reset", strobes, s0);
        chk("ready_after_reset", {31'd0, target_ready}, 32'd1);

        do_read(16'h0003, -1, 1'b0, 0);

        chk("queue_empty", exp_q.size(), 0);
        chk("strobe_count", strobes, n_reads);
        chk("ack_count", acks, n_writes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
